fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset; the ports are listed below.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset; sampled only on the rising clk edge.
REQ-004 Stall  in  1  from hazard unit; 1 freezes the PC and the F/D register.
REQ-005 NPCOp_D  in  2  next-PC select from decode: 0 = PC+4, 1 = branch, 2 = j/jal, 3 = jr.
REQ-006 BrTaken_D  in  1  branch condition (beq/bgezal) evaluated in D on forwarded operands.
REQ-007 Imm26_D  in  26  Instr_D[25:0]; low 16 bits are the branch offset.
REQ-008 RSVal_D  in  32  forwarded rs value, used as the jr target.
REQ-009 IMAddr  out  32  current PC_F, driven to the instruction memory.
REQ-010 IMRdata  in  32  combinational instruction word at IMAddr.
REQ-011 Instr_D, PC_D, PC8_D  out  32 each  F/D pipeline register contents.
REQ-012 AdEL_D  out  1  fetch address-error flag (present only with the macro in REQ-026).

Function
REQ-013 SHALL hold PC_F in a 32-bit register; IMAddr = PC_F, combinational.
REQ-014 SHALL compute NPC in sub-module npc_calc; all arithmetic is 32-bit modulo 2^32.
- NPCOp 0: PC_F+4
- NPCOp 1: if BrTaken_D, PC_D+4+(sext(Imm26_D[15:0])<<2); else PC_F+4
- NPCOp 2: {PC_D[31:28]+carry-free, i.e. (PC_D+4)[31:28], Imm26_D, 2'b00}
- NPCOp 3: RSVal_D
REQ-015 On each edge with Stall=0: PC_F <= NPC; Instr_D <= IMRdata; PC_D <= PC_F; PC8_D <= PC_F+8.
REQ-016 On each edge with Stall=1: PC_F and all F/D outputs SHALL hold their values; the redirect from D is ignored that cycle and taken on the first non-stalled edge.
REQ-017 Delay slot: the instruction fetched in the same cycle a redirect is taken SHALL enter D normally and is never squashed.
REQ-018 Redirect latency: a taken branch/jump in D at cycle n SHALL make IMAddr equal the target in cycle n+1, provided Stall=0 at n.
REQ-019 An NPCOp value that is not a legal decode state SHALL be treated as 0.
REQ-020 Target misalignment (low 2 bits != 0) SHALL NOT be corrected; the PC is loaded as computed.

Reset
REQ-021 reset=0 at an edge SHALL set PC_F=0x0000_3000, Instr_D=0, PC_D=0x0000_3000, PC8_D=0x0000_3008, AdEL_D=0.
REQ-022 Reset SHALL take priority over Stall and over any redirect in the same cycle.
REQ-023 Reset asserted mid-stall or mid-redirect SHALL leave no residual state; the first fetch after release is from 0x0000_3000.
REQ-024 Instr_D=0 (sll $0 nop) out of reset SHALL be the only bubble encoding.

Configuration
REQ-025 Exactly one compile-time option.
REQ-026 FETCH_ADDR_CHK_EN defined: if PC_F[1:0]!=0 or PC_F is outside 0x0000_3000..0x0000_6FFC, then on the next non-stalled edge Instr_D <= 0 (nop) and AdEL_D <= 1; otherwise AdEL_D <= 0. The PC sequence is unchanged.
REQ-027 FETCH_ADDR_CHK_EN undefined: no check; Instr_D always <= IMRdata; AdEL_D is absent from the port list.

Structure
REQ-028 A shared package SHALL hold:
- NPCOp encodings (NPC_PC4, NPC_BR, NPC_J, NPC_JR)
- PC_RESET = 0x0000_3000
- IM_LO = 0x0000_3000 and IM_HI = 0x0000_6FFC
- NOP = 0
REQ-029 npc_calc SHALL be a purely combinational sub-module; the PC and F/D registers SHALL live in fetch_stage.

Verification
REQ-030 Sequential run: reset release, Stall=0, NPCOp=0 for 3 cycles -> IMAddr 0x3000, 0x3004, 0x3008; PC8_D = PC_D+8 each cycle.
REQ-031 Taken beq: PC_D=0x3004, offset 0xFFFF, BrTaken=1 -> next IMAddr = 0x3004; the delay-slot word at 0x3008 reaches Instr_D.
REQ-032 jal/jr: NPCOp=2 with Imm26=0x0000C10 at PC_D=0x3010 -> IMAddr 0x3040; then NPCOp=3 with RSVal_D=0x3018 -> IMAddr 0x3018.
REQ-033 Stall with a pending jr: Stall=1 for 2 cycles while NPCOp=3 -> IMAddr and Instr_D constant; redirect occurs the cycle after Stall falls.
REQ-034 Reset during Stall=1 with NPCOp=1 taken -> PC_F=0x3000, Instr_D=0 on that edge.
REQ-035 With FETCH_ADDR_CHK_EN: jr to 0x3002 -> Instr_D=0 and AdEL_D=1 next edge; jr to 0x7000 -> same; 0x3004 -> AdEL_D=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: next-PC select codes, reset PC and instruction-memory window.
// The optional fetch address check is enabled by defining FETCH_ADDR_CHK_EN.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        NPC_PC4 = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_op_e;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_LO    = 32'h0000_3000;
    localparam logic [31:0] IM_HI    = 32'h0000_6FFC;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // Branch target is relative to the delay-slot address (PC_D + 4).
    function automatic logic [31:0] branch_target(input logic [31:0] pc_d,
                                                  input logic [15:0] off);
        return pc_d + 32'd4 + {{14{off[15]}}, off, 2'b00};
    endfunction

    function automatic logic fetch_addr_bad(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
    endfunction

endpackage

// File: rtl/fetch_stage_npc.sv
// Combinational next-PC selection (npc_calc): sequential, branch, j/jal and jr targets.
import fetch_stage_pkg::*;

module npc_calc (
    input  logic [1:0]  npc_op_i,
    input  logic        br_taken_i,
    input  logic [25:0] imm26_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] pc_f_i,
    input  logic [31:0] pc_d_i,
    output logic [31:0] npc_o
);

    logic [31:0] pc_f_plus4;
    logic [31:0] pc_d_plus4;

    assign pc_f_plus4 = pc_f_i + 32'd4;
    assign pc_d_plus4 = pc_d_i + 32'd4;

    always_comb begin
        npc_o = pc_f_plus4;
        case (npc_op_e'(npc_op_i))
            NPC_PC4: npc_o = pc_f_plus4;
            NPC_BR:  npc_o = br_taken_i ? branch_target(pc_d_i, imm26_i[15:0]) : pc_f_plus4;
            NPC_J:   npc_o = {pc_d_plus4[31:28], imm26_i, 2'b00};
            NPC_JR:  npc_o = rs_val_i;
            default: npc_o = pc_f_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, instruction-memory address and the F/D pipeline register.
// Define FETCH_ADDR_CHK_EN to add the fetch address-error check and the AdEL_D output.
import fetch_stage_pkg::*;

module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [1:0]  NPCOp_D,
    input  logic        BrTaken_D,
    input  logic [25:0] Imm26_D,
    input  logic [31:0] RSVal_D,
    output logic [31:0] IMAddr,
    input  logic [31:0] IMRdata,
    output logic [31:0] Instr_D,
    output logic [31:0] PC_D,
`ifdef FETCH_ADDR_CHK_EN
    output logic [31:0] PC8_D,
    output logic        AdEL_D
`else
    output logic [31:0] PC8_D
`endif
);

    logic [31:0] pc_f_q,    pc_f_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc_d_q;
    logic [31:0] pc8_d_q;

    npc_calc u_npc_calc (
        .npc_op_i   (NPCOp_D),
        .br_taken_i (BrTaken_D),
        .imm26_i    (Imm26_D),
        .rs_val_i   (RSVal_D),
        .pc_f_i     (pc_f_q),
        .pc_d_i     (pc_d_q),
        .npc_o      (pc_f_d)
    );

`ifdef FETCH_ADDR_CHK_EN
    logic adel_d_q, adel_d_d;

    // A bad fetch address is replaced by a nop; the PC sequence itself is untouched.
    always_comb begin
        adel_d_d  = fetch_addr_bad(pc_f_q);
        instr_d_d = adel_d_d ? NOP : IMRdata;
    end

    assign AdEL_D = adel_d_q;
`else
    assign instr_d_d = IMRdata;
`endif

    // Reset outranks Stall; Stall freezes PC and F/D so a pending redirect waits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_f_q    <= PC_RESET;
            instr_d_q <= NOP;
            pc_d_q    <= PC_RESET;
            pc8_d_q   <= PC_RESET + 32'd8;
`ifdef FETCH_ADDR_CHK_EN
            adel_d_q  <= 1'b0;
`endif
        end else if (!Stall) begin
            pc_f_q    <= pc_f_d;
            instr_d_q <= instr_d_d;
            pc_d_q    <= pc_f_q;
            pc8_d_q   <= pc_f_q + 32'd8;
`ifdef FETCH_ADDR_CHK_EN
            adel_d_q  <= adel_d_d;
`endif
        end
    end

    assign IMAddr  = pc_f_q;
    assign Instr_D = instr_d_q;
    assign PC_D    = pc_d_q;
    assign PC8_D   = pc8_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against a behavioural model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic [1:0]  NPCOp_D;
    logic        BrTaken_D;
    logic [25:0] Imm26_D;
    logic [31:0] RSVal_D;
    logic [31:0] IMAddr;
    logic [31:0] IMRdata;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PC8_D;
`ifdef FETCH_ADDR_CHK_EN
    logic        AdEL_D;
`endif

    int vectors;
    int miscompares;

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
    logic        m_adel;

    fetch_stage dut (
        .clk       (clk),
        .reset     (reset),
        .Stall     (Stall),
        .NPCOp_D   (NPCOp_D),
        .BrTaken_D (BrTaken_D),
        .Imm26_D   (Imm26_D),
        .RSVal_D   (RSVal_D),
        .IMAddr    (IMAddr),
        .IMRdata   (IMRdata),
        .Instr_D   (Instr_D),
        .PC_D      (PC_D),
`ifdef FETCH_ADDR_CHK_EN
        .PC8_D     (PC8_D),
        .AdEL_D    (AdEL_D)
`else
        .PC8_D     (PC8_D)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: a fixed scrambling of the address, never zero in practice.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    assign IMRdata = mem_word(IMAddr);

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    // Model of one clock edge, written from the architectural rules.
    task automatic model_step(input logic rst_n, input logic st, input logic [1:0] op,
                              input logic br, input logic [25:0] imm, input logic [31:0] rs);
        logic [31:0] npc;
        int          off;
        logic        bad;
        if (!rst_n) begin
            m_pc = 32'h3000; m_instr = 0; m_pcd = 32'h3000; m_pc8 = 32'h3008; m_adel = 0;
        end else if (!st) begin
            off = int'($signed(imm[15:0]));
            case (op)
                2'd1:    npc = br ? m_pcd + 32'd4 + 32'(off * 4) : m_pc + 32'd4;
                2'd2:    npc = ((m_pcd + 32'd4) & 32'hF000_0000) | (32'(imm) * 32'd4);
                2'd3:    npc = rs;
                default: npc = m_pc + 32'd4;
            endcase
`ifdef FETCH_ADDR_CHK_EN
            bad = addr_bad(m_pc);
`else
            bad = 1'b0;
`endif
            m_instr = bad ? 32'h0 : mem_word(m_pc);
            m_adel  = bad;
            m_pcd   = m_pc;
            m_pc8   = m_pc + 32'd8;
            m_pc    = npc;
        end
    endtask

    // Drive one cycle of inputs, take the edge, update the model, settle past the edge.
    task automatic do_cycle(input logic rst_n, input logic st, input logic [1:0] op,
                            input logic br, input logic [25:0] imm, input logic [31:0] rs);
        reset = rst_n; Stall = st; NPCOp_D = op; BrTaken_D = br; Imm26_D = imm; RSVal_D = rs;
        @(posedge clk);
        model_step(rst_n, st, op, br, imm, rs);
        #1;
    endtask

    task automatic test_reset();
        // Reset while stalled with a taken branch pending: reset must win.
        do_cycle(1'b0, 1'b1, 2'd1, 1'b1, 26'h000_FFFF, 32'h0);
        do_cycle(1'b0, 1'b1, 2'd1, 1'b1, 26'h000_FFFF, 32'h0);
        vectors++; if (IMAddr !== 32'h3000) begin miscompares++; $display("FAIL reset_pc got=%h exp=%h", IMAddr, 32'h3000); end
        vectors++; if (Instr_D !== 32'h0) begin miscompares++; $display("FAIL reset_instr got=%h exp=%h", Instr_D, 32'h0); end
        vectors++; if (PC_D !== 32'h3000) begin miscompares++; $display("FAIL reset_pcd got=%h exp=%h", PC_D, 32'h3000); end
        vectors++; if (PC8_D !== 32'h3008) begin miscompares++; $display("FAIL reset_pc8 got=%h exp=%h", PC8_D, 32'h3008); end
`ifdef FETCH_ADDR_CHK_EN
        vectors++; if (AdEL_D !== 1'b0) begin miscompares++; $display("FAIL reset_adel got=%b exp=0", AdEL_D); end
`endif
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            do_cycle(1'b1, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
            exp_pc = 32'h3000 + 32'(4 * i);
            vectors++; if (IMAddr !== exp_pc) begin miscompares++; $display("FAIL seq_pc i=%0d got=%h exp=%h", i, IMAddr, exp_pc); end
            vectors++; if (PC_D !== exp_pc - 4) begin miscompares++; $display("FAIL seq_pcd i=%0d got=%h exp=%h", i, PC_D, exp_pc - 4); end
            vectors++; if (PC8_D !== exp_pc + 4) begin miscompares++; $display("FAIL seq_pc8 i=%0d got=%h exp=%h", i, PC8_D, exp_pc + 4); end
            vectors++; if (Instr_D !== mem_word(exp_pc - 4)) begin miscompares++; $display("FAIL seq_instr i=%0d got=%h exp=%h", i, Instr_D, mem_word(exp_pc - 4)); end
        end
    endtask

    task automatic test_branch();
        do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
        do_cycle(1'b1, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
        do_cycle(1'b1, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
        // PC_D = 0x3004, PC_F = 0x3008: taken beq with offset -1 lands back on 0x3004.
        do_cycle(1'b1, 1'b0, 2'd1, 1'b1, 26'h000_FFFF, 32'h0);
        vectors++; if (IMAddr !== 32'h3004) begin miscompares++; $display("FAIL br_target got=%h exp=%h", IMAddr, 32'h3004); end
        vectors++; if (Instr_D !== mem_word(32'h3008)) begin miscompares++; $display("FAIL br_delay_slot got=%h exp=%h", Instr_D, mem_word(32'h3008)); end
        vectors++; if (PC_D !== 32'h3008) begin miscompares++; $display("FAIL br_pcd got=%h exp=%h", PC_D, 32'h3008); end
        // Not-taken branch falls through to PC_F+4.
        do_cycle(1'b1, 1'b0, 2'd1, 1'b0, 26'h000_0040, 32'h0);
        vectors++; if (IMAddr !== 32'h3008) begin miscompares++; $display("FAIL br_not_taken got=%h exp=%h", IMAddr, 32'h3008); end
    endtask

    task automatic test_jump();
        do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
        vectors++; if (PC_D !== 32'h3010) begin miscompares++; $display("FAIL jal_setup_pcd got=%h exp=%h", PC_D, 32'h3010); end
        do_cycle(1'b1, 1'b0, 2'd2, 1'b0, 26'h000_0C10, 32'h0);
        vectors++; if (IMAddr !== 32'h3040) begin miscompares++; $display("FAIL jal_target got=%h exp=%h", IMAddr, 32'h3040); end
        do_cycle(1'b1, 1'b0, 2'd3, 1'b0, 26'h0, 32'h3018);
        vectors++; if (IMAddr !== 32'h3018) begin miscompares++; $display("FAIL jr_target got=%h exp=%h", IMAddr, 32'h3018); end
        vectors++; if (Instr_D !== mem_word(32'h3040)) begin miscompares++; $display("FAIL jr_delay_slot got=%h exp=%h", Instr_D, mem_word(32'h3040)); end
    endtask

    task automatic test_stall_jr();
        do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
        do_cycle(1'b1, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
        do_cycle(1'b1, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            do_cycle(1'b1, 1'b1, 2'd3, 1'b0, 26'h0, 32'h0000_3100);
            vectors++; if (IMAddr !== 32'h3008) begin miscompares++; $display("FAIL stall_pc i=%0d got=%h exp=%h", i, IMAddr, 32'h3008); end
            vectors++; if (Instr_D !== mem_word(32'h3004)) begin miscompares++; $display("FAIL stall_instr i=%0d got=%h exp=%h", i, Instr_D, mem_word(32'h3004)); end
        end
        do_cycle(1'b1, 1'b0, 2'd3, 1'b0, 26'h0, 32'h0000_3100);
        vectors++; if (IMAddr !== 32'h3100) begin miscompares++; $display("FAIL stall_jr_redirect got=%h exp=%h", IMAddr, 32'h3100); end
        // Reset in the middle of a redirect leaves nothing behind.
        do_cycle(1'b0, 1'b0, 2'd3, 1'b0, 26'h0, 32'h0000_5000);
        do_cycle(1'b1, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
        vectors++; if (PC_D !== 32'h3000) begin miscompares++; $display("FAIL reset_mid_redirect got=%h exp=%h", PC_D, 32'h3000); end
        vectors++; if (Instr_D !== mem_word(32'h3000)) begin miscompares++; $display("FAIL reset_first_fetch got=%h exp=%h", Instr_D, mem_word(32'h3000)); end
    endtask

`ifdef FETCH_ADDR_CHK_EN
    task automatic test_addr_chk();
        logic [31:0] tgt[3];
        logic        exp_err[3];
        tgt = '{32'h3002, 32'h7000, 32'h3004};
        exp_err = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
            do_cycle(1'b1, 1'b0, 2'd3, 1'b0, 26'h0, tgt[i]);
            do_cycle(1'b1, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
            vectors++; if (AdEL_D !== exp_err[i]) begin miscompares++; $display("FAIL adel_flag tgt=%h got=%b exp=%b", tgt[i], AdEL_D, exp_err[i]); end
            vectors++; if (Instr_D !== (exp_err[i] ? 32'h0 : mem_word(tgt[i]))) begin miscompares++; $display("FAIL adel_instr tgt=%h got=%h", tgt[i], Instr_D); end
            vectors++; if (IMAddr !== tgt[i] + 32'd4) begin miscompares++; $display("FAIL adel_pc_seq got=%h exp=%h", IMAddr, tgt[i] + 32'd4); end
        end
    endtask
`endif

    task automatic test_random();
        logic        rst_n, st, br;
        logic [1:0]  op;
        logic [25:0] imm;
        logic [31:0] rs;
        do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 26'h0, 32'h0);
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 40) != 0);
            st    = ($urandom_range(0, 3) == 0);
            op    = 2'($urandom_range(0, 3));
            br    = 1'($urandom_range(0, 1));
            imm   = 26'($urandom);
            rs    = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + 32'(4 * $urandom_range(0, 32'hFFF));
            do_cycle(rst_n, st, op, br, imm, rs);
            vectors++; if (IMAddr !== m_pc) begin miscompares++; $display("FAIL rand_pc i=%0d got=%h exp=%h", i, IMAddr, m_pc); end
            vectors++; if (Instr_D !== m_instr) begin miscompares++; $display("FAIL rand_instr i=%0d got=%h exp=%h", i, Instr_D, m_instr); end
            vectors++; if (PC_D !== m_pcd) begin miscompares++; $display("FAIL rand_pcd i=%0d got=%h exp=%h", i, PC_D, m_pcd); end
            vectors++; if (PC8_D !== m_pc8) begin miscompares++; $display("FAIL rand_pc8 i=%0d got=%h exp=%h", i, PC8_D, m_pc8); end
`ifdef FETCH_ADDR_CHK_EN
            vectors++; if (AdEL_D !== m_adel) begin miscompares++; $display("FAIL rand_adel i=%0d got=%b exp=%b", i, AdEL_D, m_adel); end
`endif
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0; Stall = 1'b0; NPCOp_D = 2'd0; BrTaken_D = 1'b0; Imm26_D = 26'h0; RSVal_D = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall_jr();
`ifdef FETCH_ADDR_CHK_EN
        test_addr_chk();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
